// File: rtl/vending_change_pkg.sv
// Shared definitions for the vending_change change/refund dispenser.
//   state_e   : dispenser control states
//   COIN5_CR  : credit value of a 5-coin (credits are 5-unit steps)
//   COIN10_CR : credit value of a 10-coin
package vending_change_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_GAP,
    ST_FINISH,
    ST_FAULT
  } state_e;

  localparam int COIN5_CR  = 1;
  localparam int COIN10_CR = 2;

endpackage

// File: rtl/vending_change_stock.sv
// Saturating hopper stock counter, one instance per coin denomination.
//   clk, reset_n : clock, asynchronous active-low reset (loads INIT)
//   inc          : refill pulse, +1 (saturates at all-ones)
//   dec          : coin dispensed, -1 (never wraps below zero)
//   count        : current stock
// A refill and a dispense in the same cycle cancel out.
module vending_change_stock #(
  parameter int STOCK_W = 6,
  parameter int INIT    = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inc,
  input  logic               dec,
  output logic [STOCK_W-1:0] count
);

  logic [STOCK_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != '1) count_d = count_q + STOCK_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - STOCK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= STOCK_W'(INIT);
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/vending_change.sv
// Change/refund dispenser: turns a credit amount into a sequence of
// coin10/coin5 ejection requests (greedy, 10-coins first) to the hopper,
// tracking hopper stock and reporting completion or shortfall.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, amount         : refund request (sampled only when idle)
//   coin_ack              : hopper confirms the current coin was ejected
//   refill5, refill10     : +1 stock pulses
//   coin5_out, coin10_out : ejection requests, held until coin_ack
//   busy                  : dispenser not idle
//   done / short          : one-cycle completion / shortfall pulses
//   remain                : credits still owed
//   stock5, stock10       : current hopper stock counts
//
// Build option: define ACK_TIMEOUT_EN to abandon a coin that is not
// acknowledged within TIMEOUT_CYCLES and report a shortfall. Without it
// the dispenser waits for coin_ack indefinitely.
module vending_change
  import vending_change_pkg::*;
#(
  parameter int AMT_W        = 4,
  parameter int STOCK_W      = 6,
  parameter int STOCK5_INIT  = 20,
  parameter int STOCK10_INIT = 20,
  parameter int GAP_CYCLES   = 2
`ifdef ACK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [AMT_W-1:0]   amount,
  input  logic               coin_ack,
  input  logic               refill5,
  input  logic               refill10,
  output logic               coin5_out,
  output logic               coin10_out,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   remain,
  output logic [STOCK_W-1:0] stock5,
  output logic [STOCK_W-1:0] stock10
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AMT_W-1:0] CR5  = AMT_W'(COIN5_CR);
  localparam logic [AMT_W-1:0] CR10 = AMT_W'(COIN10_CR);

  state_e             state_q, state_d;
  logic [AMT_W-1:0]   remain_q, remain_d;
  logic               sel10_q, sel10_d;   // coin being ejected: 1 = 10-coin
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               dec5, dec10;

`ifdef ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    sel10_d  = sel10_q;
    gap_d    = gap_q;
    dec5     = 1'b0;
    dec10    = 1'b0;
`ifdef ACK_TIMEOUT_EN
    // Cleared outside EJECT so every coin gets a fresh timeout window.
    tmo_d    = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remain_d = amount;
          state_d  = (amount == '0) ? ST_FINISH : ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remain_q == '0) begin
          state_d = ST_FINISH;
        end else if (remain_q >= CR10 && stock10 != '0) begin
          sel10_d = 1'b1;
          state_d = ST_EJECT;
        end else if (stock5 != '0) begin
          sel10_d = 1'b0;
          state_d = ST_EJECT;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_EJECT: begin
        if (coin_ack) begin
          remain_d = remain_q - (sel10_q ? CR10 : CR5);
          dec10    = sel10_q;
          dec5     = !sel10_q;
          gap_d    = GAP_W'(GAP_CYCLES - 1);
          state_d  = ST_GAP;
        end
`ifdef ACK_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Coin abandoned: nothing paid, stock untouched.
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_SELECT;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      ST_FINISH: state_d = ST_IDLE;
      // remain keeps the unpaid credits until the next start reloads it.
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      sel10_q  <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      sel10_q  <= sel10_d;
      gap_q    <= gap_d;
    end
  end

`ifdef ACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`endif

  vending_change_stock #(
    .STOCK_W (STOCK_W),
    .INIT    (STOCK5_INIT)
  ) u_stock5 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (refill5),
    .dec     (dec5),
    .count   (stock5)
  );

  vending_change_stock #(
    .STOCK_W (STOCK_W),
    .INIT    (STOCK10_INIT)
  ) u_stock10 (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (refill10),
    .dec     (dec10),
    .count   (stock10)
  );

  assign coin10_out = (state_q == ST_EJECT) && sel10_q;
  assign coin5_out  = (state_q == ST_EJECT) && !sel10_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FINISH);
  assign short      = (state_q == ST_FAULT);
  assign remain     = remain_q;

endmodule

// File: tb/tb_vending_change.sv
// Self-checking bench for vending_change. A behavioural model computes the
// greedy payout (number of 10- and 5-coins, unpaid remainder, stock after)
// with plain arithmetic; a hopper responder acknowledges requests with a
// chosen delay and records the coin sequence. Define ACK_TIMEOUT_EN to also
// exercise the acknowledge timeout.
module tb_vending_change;

  localparam int AMT_W     = 4;
  localparam int STOCK_W   = 6;
  localparam int S5_INIT   = 20;
  localparam int S10_INIT  = 20;
  localparam int STOCK_MAX = (1 << STOCK_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [AMT_W-1:0]   amount;
  logic               coin_ack;
  logic               refill5;
  logic               refill10;
  logic               coin5_out;
  logic               coin10_out;
  logic               busy;
  logic               done;
  logic               short;
  logic [AMT_W-1:0]   remain;
  logic [STOCK_W-1:0] stock5;
  logic [STOCK_W-1:0] stock10;

  always #5 clk = ~clk;

  vending_change #(
    .AMT_W        (AMT_W),
    .STOCK_W      (STOCK_W),
    .STOCK5_INIT  (S5_INIT),
    .STOCK10_INIT (S10_INIT),
    .GAP_CYCLES   (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .amount     (amount),
    .coin_ack   (coin_ack),
    .refill5    (refill5),
    .refill10   (refill10),
    .coin5_out  (coin5_out),
    .coin10_out (coin10_out),
    .busy       (busy),
    .done       (done),
    .short      (short),
    .remain     (remain),
    .stock5     (stock5),
    .stock10    (stock10)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int    m_s5, m_s10, m_rem;
  string exp_seq;

  // Observations from one transaction ("T" = 10-coin, "F" = 5-coin)
  string obs_seq;
  int    obs_done, obs_short, obs_lat, obs_both, obs_rem, obs_hung;

  task automatic model_txn(input int amt);
    int n10, n5, rem;
    n10 = (amt / 2 < m_s10) ? amt / 2 : m_s10;
    rem = amt - 2 * n10;
    n5  = (rem < m_s5) ? rem : m_s5;
    rem = rem - n5;
    exp_seq = "";
    for (int i = 0; i < n10; i++) exp_seq = {exp_seq, "T"};
    for (int i = 0; i < n5; i++)  exp_seq = {exp_seq, "F"};
    m_s10 = m_s10 - n10;
    m_s5  = m_s5 - n5;
    m_rem = rem;
  endtask

  task automatic do_refill(input bit r5, input bit r10);
    refill5  = r5;
    refill10 = r10;
    @(negedge clk);
    refill5  = 1'b0;
    refill10 = 1'b0;
    if (r5)  m_s5  = (m_s5 < STOCK_MAX) ? m_s5 + 1 : STOCK_MAX;
    if (r10) m_s10 = (m_s10 < STOCK_MAX) ? m_s10 + 1 : STOCK_MAX;
  endtask

  // Issues one request (called at a negedge with the DUT idle) and acts as
  // the hopper until one cycle after the done/short pulse.
  task automatic run_txn(input int amt, input int ack_dly, input bit noise,
                         input bit refill_on_ack, input int budget);
    int age, cyc;
    bit fin_seen;
    obs_seq = ""; obs_done = 0; obs_short = 0; obs_lat = -1;
    obs_both = 0; obs_rem = -1; obs_hung = 0;
    start  = 1'b1;
    amount = AMT_W'(amt);
    @(negedge clk);
    amount = AMT_W'($urandom);
    cyc = 1; age = 0; fin_seen = 1'b0;
    while (1) begin
      coin_ack = 1'b0; refill10 = 1'b0; start = 1'b0;
      if (done)  obs_done++;
      if (short) obs_short++;
      if (coin5_out && coin10_out) obs_both++;
      if ((coin5_out || coin10_out) && obs_lat < 0) obs_lat = cyc;
      if (fin_seen) break;
      if (done || short) begin
        fin_seen = 1'b1;
        obs_rem  = int'(remain);
      end else if (coin5_out || coin10_out) begin
        if (age >= ack_dly) begin
          coin_ack = 1'b1;
          obs_seq  = {obs_seq, coin10_out ? "T" : "F"};
          if (refill_on_ack && coin10_out) refill10 = 1'b1;
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
        if (noise) begin
          coin_ack = 1'($urandom_range(0, 1));
          if (busy && $urandom_range(0, 3) == 0) begin
            start  = 1'b1;
            amount = AMT_W'($urandom);
          end
        end
      end
      if (cyc >= budget) begin
        obs_hung = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    coin_ack = 1'b0; refill10 = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; amount = '0; coin_ack = 1'b0;
    refill5 = 1'b0; refill10 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (coin5_out !== 1'b0)  begin errors++; $display("FAIL rst_coin5 got %b want 0", coin5_out); end
    checks++; if (coin10_out !== 1'b0) begin errors++; $display("FAIL rst_coin10 got %b want 0", coin10_out); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || short !== 1'b0) begin errors++; $display("FAIL rst_pulses got done=%b short=%b want 0/0", done, short); end
    checks++; if (remain !== '0)       begin errors++; $display("FAIL rst_remain got %0d want 0", remain); end
    checks++; if (stock5 !== STOCK_W'(S5_INIT))   begin errors++; $display("FAIL rst_stock5 got %0d want %0d", stock5, S5_INIT); end
    checks++; if (stock10 !== STOCK_W'(S10_INIT)) begin errors++; $display("FAIL rst_stock10 got %0d want %0d", stock10, S10_INIT); end
    reset_n = 1'b1;
    m_s5 = S5_INIT; m_s10 = S10_INIT;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
  endtask

  task automatic test_amount7();
    model_txn(7);
    run_txn(7, 0, 1'b0, 1'b0, 500);
    checks++; if (obs_seq != exp_seq) begin errors++; $display("FAIL amt7_seq got '%s' want '%s'", obs_seq, exp_seq); end
    checks++; if (obs_lat !== 2)      begin errors++; $display("FAIL amt7_latency got %0d want 2", obs_lat); end
    checks++; if (obs_done !== 1 || obs_short !== 0) begin errors++; $display("FAIL amt7_pulses got done=%0d short=%0d want 1/0", obs_done, obs_short); end
    checks++; if (obs_rem !== m_rem)  begin errors++; $display("FAIL amt7_remain got %0d want %0d", obs_rem, m_rem); end
    checks++; if (int'(stock10) !== m_s10 || int'(stock5) !== m_s5) begin errors++; $display("FAIL amt7_stock got %0d/%0d want %0d/%0d", stock10, stock5, m_s10, m_s5); end
    checks++; if (obs_both !== 0 || obs_hung !== 0) begin errors++; $display("FAIL amt7_proto got both=%0d hung=%0d want 0/0", obs_both, obs_hung); end
  endtask

  // Empties the 10-coin hopper, then pays 3 credits in 5-coins only.
  task automatic test_no_tens();
    int amt;
    while (m_s10 > 0) begin
      amt = 2 * ((m_s10 < 7) ? m_s10 : 7);
      model_txn(amt);
      run_txn(amt, int'($urandom_range(0, 2)), 1'b1, 1'b0, 1000);
      checks++; if (obs_seq != exp_seq || obs_done !== 1) begin errors++; $display("FAIL drain10 amt=%0d got '%s' done=%0d want '%s' done=1", amt, obs_seq, obs_done, exp_seq); end
      if (obs_hung != 0) break;
    end
    model_txn(3);
    run_txn(3, 1, 1'b0, 1'b0, 500);
    checks++; if (obs_seq != exp_seq) begin errors++; $display("FAIL no10_seq got '%s' want '%s'", obs_seq, exp_seq); end
    checks++; if (obs_done !== 1 || obs_short !== 0) begin errors++; $display("FAIL no10_pulses got done=%0d short=%0d want 1/0", obs_done, obs_short); end
    checks++; if (int'(stock5) !== m_s5 || stock10 !== '0) begin errors++; $display("FAIL no10_stock got %0d/%0d want %0d/0", stock5, stock10, m_s5); end
  endtask

  // Leaves one coin of each kind, then asks for 5 credits: 3 paid, 2 owed.
  task automatic test_short();
    int amt;
    while (m_s5 > 0) begin
      amt = (m_s5 < 15) ? m_s5 : 15;
      model_txn(amt);
      run_txn(amt, 0, 1'b0, 1'b0, 1000);
      checks++; if (obs_seq != exp_seq || obs_done !== 1) begin errors++; $display("FAIL drain5 amt=%0d got '%s' done=%0d want '%s' done=1", amt, obs_seq, obs_done, exp_seq); end
      if (obs_hung != 0) break;
    end
    do_refill(1'b1, 1'b1);
    model_txn(5);
    run_txn(5, 0, 1'b0, 1'b0, 500);
    checks++; if (obs_seq != exp_seq) begin errors++; $display("FAIL short_seq got '%s' want '%s'", obs_seq, exp_seq); end
    checks++; if (obs_short !== 1 || obs_done !== 0) begin errors++; $display("FAIL short_pulses got short=%0d done=%0d want 1/0", obs_short, obs_done); end
    checks++; if (obs_rem !== m_rem) begin errors++; $display("FAIL short_remain got %0d want %0d", obs_rem, m_rem); end
    repeat (3) @(negedge clk);
    checks++; if (int'(remain) !== m_rem) begin errors++; $display("FAIL short_remain_held got %0d want %0d", remain, m_rem); end
  endtask

  task automatic test_refill();
    do_refill(1'b0, 1'b1);
    do_refill(1'b0, 1'b1);
    model_txn(2);
    m_s10 = m_s10 + 1;  // refill lands in the same cycle as the 10-coin ack
    run_txn(2, 0, 1'b0, 1'b1, 500);
    checks++; if (obs_seq != exp_seq || obs_done !== 1) begin errors++; $display("FAIL refill_ack_seq got '%s' done=%0d want '%s' done=1", obs_seq, obs_done, exp_seq); end
    checks++; if (int'(stock10) !== m_s10) begin errors++; $display("FAIL refill_ack_stock10 got %0d want %0d", stock10, m_s10); end
    repeat (STOCK_MAX + 5) do_refill(1'b1, 1'b1);
    checks++; if (int'(stock5) !== m_s5 || int'(stock10) !== m_s10) begin errors++; $display("FAIL refill_sat got %0d/%0d want %0d/%0d", stock5, stock10, m_s5, m_s10); end
  endtask

  // Random requests issued back to back, random ack delays, stray starts
  // and acks while busy, occasional refills between requests.
  task automatic test_back_to_back();
    int amt;
    for (int t = 0; t < 14; t++) begin
      amt = int'($urandom_range(0, 15));
      model_txn(amt);
      run_txn(amt, int'($urandom_range(0, 3)), 1'b1, 1'b0, 1000);
      checks++; if (obs_seq != exp_seq) begin errors++; $display("FAIL b2b_seq t=%0d amt=%0d got '%s' want '%s'", t, amt, obs_seq, exp_seq); end
      checks++; if (obs_done !== (m_rem == 0 ? 1 : 0) || obs_short !== (m_rem == 0 ? 0 : 1)) begin errors++; $display("FAIL b2b_pulses t=%0d got done=%0d short=%0d rem_want=%0d", t, obs_done, obs_short, m_rem); end
      checks++; if (obs_rem !== m_rem) begin errors++; $display("FAIL b2b_remain t=%0d got %0d want %0d", t, obs_rem, m_rem); end
      checks++; if (int'(stock5) !== m_s5 || int'(stock10) !== m_s10) begin errors++; $display("FAIL b2b_stock t=%0d got %0d/%0d want %0d/%0d", t, stock5, stock10, m_s5, m_s10); end
      if ($urandom_range(0, 2) == 0) do_refill(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    int waited, pulses;
    start  = 1'b1;
    amount = AMT_W'(10);
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (!(coin5_out || coin10_out) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (!(coin5_out || coin10_out)) begin errors++; $display("FAIL rstmid_no_request got 0 want request within 20 cycles"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (coin5_out !== 1'b0 || coin10_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got c5=%b c10=%b busy=%b want 0/0/0", coin5_out, coin10_out, busy); end
    checks++; if (remain !== '0 || stock5 !== STOCK_W'(S5_INIT) || stock10 !== STOCK_W'(S10_INIT)) begin errors++; $display("FAIL rstmid_state got rem=%0d s5=%0d s10=%0d want 0/%0d/%0d", remain, stock5, stock10, S5_INIT, S10_INIT); end
    @(negedge clk);
    reset_n = 1'b1;
    m_s5 = S5_INIT; m_s10 = S10_INIT;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || short || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", pulses); end
  endtask

`ifdef ACK_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(3, 1000000, 1'b0, 1'b0, 600);
    checks++; if (obs_seq != "" || obs_short !== 1 || obs_done !== 0) begin errors++; $display("FAIL tmo_result got seq='%s' short=%0d done=%0d want ''/1/0", obs_seq, obs_short, obs_done); end
    checks++; if (obs_rem !== 3) begin errors++; $display("FAIL tmo_remain got %0d want 3", obs_rem); end
    checks++; if (int'(stock5) !== m_s5 || int'(stock10) !== m_s10) begin errors++; $display("FAIL tmo_stock got %0d/%0d want %0d/%0d", stock5, stock10, m_s5, m_s10); end
  endtask
`endif

  initial begin
    test_reset();
    test_amount7();
    test_no_tens();
    test_short();
    test_refill();
    test_back_to_back();
    test_reset_mid();
`ifdef ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
